// File: rtl/fl_hw_responder.sv
// fl_hw_responder: FrameLink sink with seeded LFSR ready throttling, counters and protocol checks
module fl_hw_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int DREM_WIDTH = 3,
  parameter int BT_DELAY_EN_WT = 0,
  parameter int BT_DELAY_DI_WT = 10,
  parameter int BT_DELAY_LOW = 0,
  parameter int BT_DELAY_HIGH = 10,
  parameter int IT_DELAY_EN_WT = 0,
  parameter int IT_DELAY_DI_WT = 10,
  parameter int IT_DELAY_LOW = 0,
  parameter int IT_DELAY_HIGH = 10,
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic [DREM_WIDTH-1:0] RX_REM,
  input  logic                  RX_SOF_N,
  input  logic                  RX_SOP_N,
  input  logic                  RX_EOF_N,
  input  logic                  RX_EOP_N,
  input  logic                  RX_SRC_RDY_N,
  output logic                  RX_DST_RDY_N,
  input  logic                  ENABLE,
  output logic [31:0]           FRAME_CNT,
  output logic [31:0]           WORD_CNT,
  output logic [31:0]           BYTE_CNT,
  output logic                  ERR_PROTO,
  output logic                  BUSY
);
  typedef enum logic {XFER, WAIT} state_t;
  localparam logic [31:0] BT_SUM = 32'(BT_DELAY_EN_WT + BT_DELAY_DI_WT);
  localparam logic [31:0] BT_MOD = BT_SUM == 0 ? 32'd1 : BT_SUM;
  localparam logic [31:0] BT_SPAN = 32'(BT_DELAY_HIGH - BT_DELAY_LOW + 1);
  localparam logic [31:0] IT_SUM = 32'(IT_DELAY_EN_WT + IT_DELAY_DI_WT);
  localparam logic [31:0] IT_MOD = IT_SUM == 0 ? 32'd1 : IT_SUM;
  localparam logic [31:0] IT_SPAN = 32'(IT_DELAY_HIGH - IT_DELAY_LOW + 1);
  localparam logic [31:0] BPW = 32'(DATA_WIDTH / 8);
  state_t state, state_nx;
  logic [15:0] lfsr, lfsr_nx;
  logic [31:0] cnt, cnt_nx, d, bt_d, it_d;
  logic acc, bt_en, it_en, err_word, rdy_n_nx, unused_data;
  assign unused_data = ^RX_DATA;
  assign acc = !RX_SRC_RDY_N && !RX_DST_RDY_N;
  assign lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  assign bt_en = BT_SUM != 0 && 32'(lfsr_nx[15:8]) % BT_MOD < 32'(BT_DELAY_EN_WT);
  assign it_en = IT_SUM != 0 && 32'(lfsr_nx[15:8]) % IT_MOD < 32'(IT_DELAY_EN_WT);
  assign bt_d = bt_en ? 32'(BT_DELAY_LOW) + 32'(lfsr_nx[7:0]) % BT_SPAN : '0;
  assign it_d = it_en ? 32'(IT_DELAY_LOW) + 32'(lfsr_nx[7:0]) % IT_SPAN : '0;
  assign d = RX_EOF_N ? it_d : bt_d;
  assign err_word = (!RX_SOF_N && BUSY) || (RX_SOF_N && !BUSY) ||
                    (!RX_EOF_N && RX_EOP_N) || (!RX_SOF_N && RX_SOP_N);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    rdy_n_nx = !ENABLE;
    if (state == XFER) begin
      if (acc && d != 0) begin
        state_nx = WAIT;
        cnt_nx = d;
        rdy_n_nx = 1'b1;
      end
    end else begin
      rdy_n_nx = 1'b1;
      if (ENABLE) begin
        cnt_nx = cnt - 32'd1;
        state_nx = cnt == 32'd1 ? XFER : WAIT;
        rdy_n_nx = cnt != 32'd1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= XFER;
      cnt <= '0;
      lfsr <= SEED;
      RX_DST_RDY_N <= 1'b1;
      FRAME_CNT <= '0;
      WORD_CNT <= '0;
      BYTE_CNT <= '0;
      ERR_PROTO <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      RX_DST_RDY_N <= rdy_n_nx;
      if (acc) begin
        lfsr <= lfsr_nx;
        WORD_CNT <= WORD_CNT + 32'd1;
        BYTE_CNT <= BYTE_CNT + (RX_EOP_N ? BPW : 32'(RX_REM) + 32'd1);
        FRAME_CNT <= FRAME_CNT + 32'(!RX_EOF_N);
        BUSY <= !RX_EOF_N ? 1'b0 : !RX_SOF_N ? 1'b1 : BUSY;
        ERR_PROTO <= ERR_PROTO | err_word;
      end
    end
  end
endmodule

// File: tb/tb_fl_hw_responder.sv
// tb_fl_hw_responder: vector table plus scoreboard bench for fl_hw_responder
module tb_fl_hw_responder;
  typedef struct {logic [31:0] fc, wc, bc; logic busy, err;} exp_t;
  typedef struct {logic rst, s, e, sp, ep; logic [2:0] r; logic busy, err;} vec_t;
  logic CLK = 0, RESET_N = 0, ENABLE = 1;
  logic sof_n = 1, eof_n = 1, sop_n = 1, eop_n = 1, src_n = 1;
  logic [2:0] rem = 0;
  logic [63:0] data = 0;
  logic rdy[4], err[4], busy[4];
  logic [31:0] fc[4], wc[4], bc[4];
  int sel = 0, checks = 0, errors = 0;
  int unsigned m_fc, m_wc, m_bc;
  logic m_busy, m_err;
  logic [15:0] m_lfsr;
  exp_t sb[$];
  vec_t tbl[10];
  always #5 CLK = ~CLK;
  fl_hw_responder u_a (.CLK(CLK), .RESET_N(RESET_N), .RX_DATA(data), .RX_REM(rem), .RX_SOF_N(sof_n),
    .RX_SOP_N(sop_n), .RX_EOF_N(eof_n), .RX_EOP_N(eop_n), .RX_SRC_RDY_N(src_n), .RX_DST_RDY_N(rdy[0]),
    .ENABLE(ENABLE), .FRAME_CNT(fc[0]), .WORD_CNT(wc[0]), .BYTE_CNT(bc[0]), .ERR_PROTO(err[0]), .BUSY(busy[0]));
  fl_hw_responder #(.BT_DELAY_EN_WT(1), .BT_DELAY_DI_WT(0), .BT_DELAY_LOW(4), .BT_DELAY_HIGH(4)) u_b (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(data), .RX_REM(rem), .RX_SOF_N(sof_n),
    .RX_SOP_N(sop_n), .RX_EOF_N(eof_n), .RX_EOP_N(eop_n), .RX_SRC_RDY_N(src_n), .RX_DST_RDY_N(rdy[1]),
    .ENABLE(ENABLE), .FRAME_CNT(fc[1]), .WORD_CNT(wc[1]), .BYTE_CNT(bc[1]), .ERR_PROTO(err[1]), .BUSY(busy[1]));
  fl_hw_responder #(.IT_DELAY_EN_WT(1), .IT_DELAY_DI_WT(0), .IT_DELAY_LOW(2), .IT_DELAY_HIGH(2)) u_c (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(data), .RX_REM(rem), .RX_SOF_N(sof_n),
    .RX_SOP_N(sop_n), .RX_EOF_N(eof_n), .RX_EOP_N(eop_n), .RX_SRC_RDY_N(src_n), .RX_DST_RDY_N(rdy[2]),
    .ENABLE(ENABLE), .FRAME_CNT(fc[2]), .WORD_CNT(wc[2]), .BYTE_CNT(bc[2]), .ERR_PROTO(err[2]), .BUSY(busy[2]));
  fl_hw_responder #(.BT_DELAY_EN_WT(1), .BT_DELAY_DI_WT(1), .BT_DELAY_LOW(1), .BT_DELAY_HIGH(3),
    .IT_DELAY_EN_WT(1), .IT_DELAY_DI_WT(2), .IT_DELAY_LOW(0), .IT_DELAY_HIGH(2), .SEED(16'hACE1)) u_d (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(data), .RX_REM(rem), .RX_SOF_N(sof_n),
    .RX_SOP_N(sop_n), .RX_EOF_N(eof_n), .RX_EOP_N(eop_n), .RX_SRC_RDY_N(src_n), .RX_DST_RDY_N(rdy[3]),
    .ENABLE(ENABLE), .FRAME_CNT(fc[3]), .WORD_CNT(wc[3]), .BYTE_CNT(bc[3]), .ERR_PROTO(err[3]), .BUSY(busy[3]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int draw(input logic [15:0] l, input int en, input int di, input int lo, input int hi);
    if (en + di == 0) return 0;
    return (int'(l[15:8]) % (en + di) < en) ? lo + int'(l[7:0]) % (hi - lo + 1) : 0;
  endfunction
  task automatic do_reset();
    src_n = 1;
    ENABLE = 1;
    RESET_N = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      chk("rdy_in_reset", rdy[sel], 1);
    end
    RESET_N = 1;
    chk("cnt_reset", fc[sel] | wc[sel] | bc[sel], 0);
    chk("err_busy_reset", {err[sel], busy[sel]}, 0);
    @(posedge CLK);
    #1;
    chk("rdy_after_reset", rdy[sel], 0);
    m_fc = 0; m_wc = 0; m_bc = 0; m_busy = 0; m_err = 0; m_lfsr = 16'hACE1;
    sb.delete();
  endtask
  task automatic send(input logic s, input logic e, input logic sp, input logic ep, input logic [2:0] r,
                      output int waited);
    exp_t x;
    logic ok, got;
    m_wc++;
    m_bc += ep ? 32'd8 : 32'(r) + 32'd1;
    if (!e) m_fc++;
    if ((!s && m_busy) || (s && !m_busy) || (!e && ep) || (!s && sp)) m_err = 1;
    m_busy = !e ? 1'b0 : !s ? 1'b1 : m_busy;
    x = '{m_fc, m_wc, m_bc, m_busy, m_err};
    sb.push_back(x);
    sof_n = s; eof_n = e; sop_n = sp; eop_n = ep; rem = r; data = {$urandom, $urandom}; src_n = 0;
    waited = 0;
    got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      ok = !rdy[sel];
      @(posedge CLK);
      #1;
      if (ok) got = 1;
      else waited++;
    end
    src_n = 1;
    x = sb.pop_front();
    chk("accept_timeout", got, 1);
    if (got) begin
      chk("frame_cnt", fc[sel], x.fc);
      chk("word_cnt", wc[sel], x.wc);
      chk("byte_cnt", bc[sel], x.bc);
      chk("busy", busy[sel], x.busy);
      chk("err_proto", err[sel], x.err);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int w, w1, w2, w3, n, ew;
    tbl[0] = '{1, 0, 1, 0, 1, 0, 1, 0};
    tbl[1] = '{0, 1, 1, 1, 1, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 1, 0, 3, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 7, 0, 0};
    tbl[4] = '{1, 0, 1, 1, 1, 0, 1, 1};
    tbl[5] = '{1, 0, 1, 0, 1, 0, 1, 0};
    tbl[6] = '{0, 1, 0, 1, 1, 0, 0, 1};
    tbl[7] = '{1, 1, 1, 1, 1, 0, 0, 1};
    tbl[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    tbl[9] = '{0, 0, 1, 0, 1, 0, 1, 1};
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].s, tbl[i].e, tbl[i].sp, tbl[i].ep, tbl[i].r, w);
      chk($sformatf("tbl%0d_busy", i), busy[0], tbl[i].busy);
      chk($sformatf("tbl%0d_err", i), err[0], tbl[i].err);
    end
    send(1, 0, 1, 0, 0, w);
    for (int f = 0; f < 20; f++) begin
      send(0, 1, 0, 1, 0, w);
      send(1, 0, 1, 0, 7, w);
    end
    chk("err_sticky", err[0], 1);
    send(0, 1, 0, 1, 0, w);
    chk("busy_mid_frame", busy[0], 1);
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 5; k++) begin
        send(k != 0, k != 4, k != 0, k != 4, k == 4 ? 3'd3 : 3'd0, w);
        chk("b2b_wait", w, 0);
        chk("b2b_rdy", rdy[0], 0);
      end
    chk("b2b_frames", fc[0], 3);
    chk("b2b_words", wc[0], 15);
    chk("b2b_bytes", bc[0], 108);
    sel = 1;
    do_reset();
    send(0, 0, 0, 0, 0, w);
    chk("bt_first_wait", w, 0);
    chk("bt_rdy_rise", rdy[1], 1);
    send(0, 0, 0, 0, 0, w);
    chk("bt_wait", w, 4);
    n = 0;
    for (int k = 0; k < 30 && rdy[1]; k++) begin
      n++;
      ENABLE = (k >= 1 && k < 4) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #1;
    end
    ENABLE = 1;
    chk("pause_rdy_cycles", n, 7);
    chk("pause_words", wc[1], 2);
    chk("pause_frames", fc[1], 2);
    sel = 2;
    do_reset();
    send(0, 1, 0, 1, 0, w1);
    send(1, 1, 1, 1, 0, w2);
    send(1, 0, 1, 0, 5, w3);
    chk("it_w1", w1, 0);
    chk("it_w2", w2, 2);
    chk("it_w3", w3, 2);
    chk("it_total", w1 + w2 + w3 + 3, 7);
    sel = 3;
    do_reset();
    ew = 0;
    for (int k = 0; k < 12; k++) begin
      send(k % 3 != 0, k % 3 != 2, k % 3 != 0, k % 3 != 2, 3'(k), w);
      chk($sformatf("lfsr_wait%0d", k), w, ew);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
      ew = (k % 3 == 2) ? draw(m_lfsr, 1, 1, 1, 3) : draw(m_lfsr, 1, 2, 0, 2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
